// File: rtl/axi4_lite_master_p.sv
// AXI4-Lite master: single-request command port bridged to the five AXI4-Lite channels.
// Optional feature macro: AXI_MASTER_WSTRB_EN (drive WSTRB from the latched wstrb operand).
module axi4_lite_master_p #(
    parameter  int ADDR_WIDTH = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic                  transfer,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    output logic                  ready,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            resp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [1:0]            resp_q, resp_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

`ifndef AXI_MASTER_WSTRB_EN
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb;
`endif

    // Every output register is loaded from its next-state value, so no output
    // ever depends combinationally on a READY/VALID input.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wstrb_d   = wstrb_q;
        resp_d    = resp_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ready_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (transfer) begin
                    addr_d    = addr;
                    wdata_d   = wdata;
`ifdef AXI_MASTER_WSTRB_EN
                    wstrb_d   = wstrb;
`endif
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (write) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (awvalid_q && AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (BVALID) begin
                    bready_d = 1'b0;
                    resp_d   = BRESP;
                    ready_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (RVALID) begin
                    rready_d = 1'b0;
                    rdata_d  = RDATA;
                    resp_d   = RRESP;
                    ready_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifndef AXI_MASTER_WSTRB_EN
        // Full-word writes only: strobes follow WVALID.
        wstrb_d = wvalid_d ? {STRB_WIDTH{1'b1}} : {STRB_WIDTH{1'b0}};
`endif
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wstrb_q   <= '0;
            resp_q    <= 2'b00;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wstrb_q   <= wstrb_d;
            resp_q    <= resp_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign AWADDR  = addr_q;
    assign ARADDR  = addr_q;
    assign AWVALID = awvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign rdata   = rdata_q;
    assign resp    = resp_q;

endmodule

// File: tb/tb_axi4_lite_master_p.sv
// Bench for axi4_lite_master_p (64-bit data, 8-bit address): delay-programmable slave
// plus a transaction-level model of expected latency, channel timing and results.
module tb_axi4_lite_master_p;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [AW-1:0] AWADDR, ARADDR, addr;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0] WDATA, RDATA, wdata, rdata;
    logic [SW-1:0] WSTRB, wstrb;
    logic [1:0]    BRESP, RRESP, resp;
    logic          transfer, write, ready, busy;

    axi4_lite_master_p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready), .busy(busy), .rdata(rdata), .resp(resp)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave: each READY/response rises after a programmed number of cycles of waiting.
    int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int            aw_hs = 0, ar_hs = 0;
    logic [1:0]    cur_bresp = 2'b00, cur_rresp = 2'b00;
    logic [DW-1:0] cur_rdata = '0;
    logic [AW-1:0] got_awaddr = '0, got_araddr = '0;
    logic [DW-1:0] got_wdata = '0;
    logic [SW-1:0] got_wstrb = '0;

    initial begin
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        forever begin
            @(negedge ACLK);
            if (AWVALID) begin AWREADY = (aw_wait >= aw_dly); aw_wait++; end
            else begin AWREADY = 0; aw_wait = 0; end
            if (AWVALID && AWREADY) begin got_awaddr = AWADDR; aw_hs++; end
            if (WVALID) begin WREADY = (w_wait >= w_dly); w_wait++; end
            else begin WREADY = 0; w_wait = 0; end
            if (WVALID && WREADY) begin got_wdata = WDATA; got_wstrb = WSTRB; end
            if (BREADY) begin BVALID = (b_wait >= b_dly); BRESP = cur_bresp; b_wait++; end
            else begin BVALID = 0; BRESP = 2'($urandom); b_wait = 0; end
            if (ARVALID) begin ARREADY = (ar_wait >= ar_dly); ar_wait++; end
            else begin ARREADY = 0; ar_wait = 0; end
            if (ARVALID && ARREADY) begin got_araddr = ARADDR; ar_hs++; end
            if (RREADY) begin
                RVALID = (r_wait >= r_dly); r_wait++;
                RDATA  = RVALID ? cur_rdata : {$urandom, $urandom};
                RRESP  = RVALID ? cur_rresp : 2'($urandom);
            end else begin
                RVALID = 0; r_wait = 0; RDATA = {$urandom, $urandom};
            end
        end
    end

    // Transaction-level model state.
    logic [DW-1:0] exp_rdata = '0;
    logic [1:0]    exp_resp  = 2'b00;
    int            exp_aw_cnt = 0, exp_ar_cnt = 0;

    // Caller is at a negedge with the DUT idle. Returns at the negedge of the ready cycle.
    task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [1:0] rsp,
                          input int d_aw, input int d_w, input int d_b,
                          input int d_ar, input int d_r, input bit noise);
        int            m, exp_lat;
        logic [SW-1:0] exp_s;
        chk("start_busy", busy, 0);
        aw_dly = d_aw; w_dly = d_w; b_dly = d_b; ar_dly = d_ar; r_dly = d_r;
        cur_bresp = rsp; cur_rresp = rsp; cur_rdata = d;
        transfer = 1; write = wr; addr = a; wdata = d; wstrb = s;
        m       = wr ? ((d_aw > d_w) ? d_aw : d_w) : d_ar;
        exp_lat = wr ? 2 + m + d_b : 2 + d_ar + d_r;
        for (int lat = 0; lat <= exp_lat; lat++) begin
            @(negedge ACLK);
            transfer = 0; write = 1'($urandom); addr = AW'($urandom);
            wdata = {$urandom, $urandom}; wstrb = SW'($urandom);
            if (lat == exp_lat) begin
                chk("ready", ready, 1);
                chk("busy_in_ready", busy, 0);
                chk("valids_off", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
                break;
            end
            chk("ready_early", ready, 0);
            chk("busy", busy, 1);
            if (wr) begin
                chk("awvalid", AWVALID, lat <= d_aw);
                chk("wvalid", WVALID, lat <= d_w);
                chk("bready", BREADY, lat >= 1 + m);
                chk("rd_chan_idle", {ARVALID, RREADY}, 0);
            end else begin
                chk("arvalid", ARVALID, lat <= d_ar);
                chk("rready", RREADY, lat >= 1 + d_ar);
                chk("wr_chan_idle", {AWVALID, WVALID, BREADY}, 0);
            end
            if (noise) transfer = ($urandom_range(0, 2) == 0);
        end
        if (wr) begin
`ifdef AXI_MASTER_WSTRB_EN
            exp_s = s;
`else
            exp_s = '1;
`endif
            exp_aw_cnt++;
            chk("awaddr", got_awaddr, a);
            chk("wdata", got_wdata, d);
            chk("wstrb", got_wstrb, exp_s);
        end else begin
            exp_ar_cnt++;
            exp_rdata = d;
            chk("araddr", got_araddr, a);
        end
        exp_resp = rsp;
        chk("rdata", rdata, exp_rdata);
        chk("resp", resp, exp_resp);
        chk("aw_count", aw_hs, exp_aw_cnt);
        chk("ar_count", ar_hs, exp_ar_cnt);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ACLK);
            chk("idle_ready", ready, 0);
            chk("idle_busy", busy, 0);
`ifndef AXI_MASTER_WSTRB_EN
            chk("idle_wstrb", WSTRB, 0);
`endif
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, ready, busy}, 0);
        chk("rst_awaddr", AWADDR, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_wdata", WDATA, 0);
        chk("rst_wstrb", WSTRB, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp", resp, 0);
    endtask

    initial begin
        ARESETn = 0; transfer = 0; write = 0; addr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge ACLK);
        chk_reset_state();
        ARESETn = 1;
        idle_cycles(2);

        // Directed: plain write, skewed write, delayed read with SLVERR.
        do_txn(1, 8'h04, 64'h0000_0000_DEAD_BEEF, 8'h0F, 2'b00, 0, 0, 0, 0, 0, 0);
        idle_cycles(1);
        do_txn(1, 8'h10, 64'h0123_4567_89AB_CDEF, 8'hF0, 2'b00, 5, 0, 0, 0, 0, 0);
        idle_cycles(1);
        do_txn(0, 8'h08, 64'hCAFE_F00D_1234_5678, 8'h00, 2'b10, 0, 0, 0, 0, 4, 0);
        idle_cycles(3);
        chk("rdata_hold", rdata, 64'hCAFE_F00D_1234_5678);
        chk("resp_hold", resp, 2'b10);

        // Back-to-back write then read, with transfer pulses while busy.
        do_txn(1, 8'h20, 64'hFFEE_DDCC_BBAA_9988, 8'h3C, 2'b01, 1, 2, 1, 0, 0, 1);
        do_txn(0, 8'h24, 64'h1111_2222_3333_4444, 8'h00, 2'b00, 0, 0, 0, 2, 1, 1);
        do_txn(1, 8'h28, 64'h5555_6666_7777_8888, 8'hFF, 2'b11, 0, 3, 2, 0, 0, 1);

        // Reset while waiting for the write response.
        aw_dly = 0; w_dly = 0; b_dly = 20; cur_bresp = 2'b00;
        transfer = 1; write = 1; addr = 8'h3C; wdata = 64'hA5A5_A5A5_5A5A_5A5A; wstrb = 8'hFF;
        @(negedge ACLK);
        transfer = 0;
        @(negedge ACLK);
        chk("pre_rst_bready", BREADY, 1);
        ARESETn = 0;
        exp_aw_cnt++;
        exp_rdata = '0;
        exp_resp  = 2'b00;
        @(negedge ACLK);
        chk_reset_state();
        ARESETn = 1;
        idle_cycles(3);
        do_txn(1, 8'h40, 64'h0BAD_C0DE_0000_0001, 8'h81, 2'b00, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with random slave stalls, gaps and busy-time pulses.
        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom), AW'($urandom), {$urandom, $urandom}, SW'($urandom),
                   2'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                   1'($urandom));
            idle_cycles($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
